// File: rtl/uart_tx_buffered.sv
// uart_tx_buffered: 8N1 UART transmitter fed from a circular byte FIFO.
// Ports: i_Clock/i_Rst_n (async active-low), i_Tx_DV/i_Tx_Byte push side,
// o_Tx_Ready (not full, or a pop is freeing a slot this cycle),
// o_Tx_Serial registered line (idle high), o_Tx_Active frame in progress,
// o_Tx_Done one-cycle end-of-stop pulse, o_Fifo_Count queued bytes.
module uart_tx_buffered #(
  parameter int CLKS_PER_BIT = 87,
  parameter int FIFO_DEPTH = 16
) (
  input  logic                              i_Clock,
  input  logic                              i_Rst_n,
  input  logic                              i_Tx_DV,
  input  logic [7:0]                        i_Tx_Byte,
  output logic                              o_Tx_Ready,
  output logic                              o_Tx_Serial,
  output logic                              o_Tx_Active,
  output logic                              o_Tx_Done,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]   o_Fifo_Count
);
  localparam int CW = $clog2(FIFO_DEPTH + 1);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int BW = $clog2(CLKS_PER_BIT);
  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;
  state_t state, state_nx;
  logic [BW-1:0] clk_cnt, clk_cnt_nx;
  logic [2:0] idx, idx_nx;
  logic [7:0] shift, shift_nx;
  logic serial_nx, active_nx, done_nx;
  logic [7:0] mem [FIFO_DEPTH];
  logic [AW-1:0] rd, wr;
  logic [CW-1:0] count;
  logic bit_end, pop, push;
  assign bit_end = clk_cnt == BW'(CLKS_PER_BIT - 1);
  assign pop = count != '0 && (state == IDLE || (state == STOP && bit_end));
  // A pop at full frees a slot on the same edge, so a push may ride along.
  assign o_Tx_Ready = count < CW'(FIFO_DEPTH) || pop;
  assign push = i_Tx_DV && o_Tx_Ready;
  assign o_Fifo_Count = count;
  always_comb begin
    state_nx = state;
    clk_cnt_nx = bit_end ? '0 : clk_cnt + BW'(1);
    idx_nx = idx;
    shift_nx = pop ? mem[rd] : shift;
    serial_nx = o_Tx_Serial;
    active_nx = o_Tx_Active;
    done_nx = 1'b0;
    case (state)
      IDLE: begin
        clk_cnt_nx = '0;
        serial_nx = !pop;
        active_nx = pop;
        state_nx = pop ? START : IDLE;
      end
      START: if (bit_end) begin
        state_nx = DATA;
        idx_nx = '0;
        serial_nx = shift[0];
      end
      DATA: if (bit_end) begin
        idx_nx = idx + 3'd1;
        state_nx = idx == 3'd7 ? STOP : DATA;
        serial_nx = idx == 3'd7 ? 1'b1 : shift[idx + 3'd1];
      end
      STOP: if (bit_end) begin
        done_nx = 1'b1;
        state_nx = pop ? START : IDLE;
        serial_nx = !pop;
        active_nx = pop;
      end
      default: begin
        state_nx = IDLE;
        clk_cnt_nx = '0;
        serial_nx = 1'b1;
        active_nx = 1'b0;
      end
    endcase
  end
  always_ff @(posedge i_Clock or negedge i_Rst_n) begin
    if (!i_Rst_n) begin
      state <= IDLE;
      clk_cnt <= '0;
      idx <= '0;
      shift <= '0;
      o_Tx_Serial <= 1'b1;
      o_Tx_Active <= 1'b0;
      o_Tx_Done <= 1'b0;
      rd <= '0;
      wr <= '0;
      count <= '0;
    end else begin
      state <= state_nx;
      clk_cnt <= clk_cnt_nx;
      idx <= idx_nx;
      shift <= shift_nx;
      o_Tx_Serial <= serial_nx;
      o_Tx_Active <= active_nx;
      o_Tx_Done <= done_nx;
      rd <= pop ? rd + AW'(1) : rd;
      wr <= push ? wr + AW'(1) : wr;
      count <= count + CW'(push) - CW'(pop);
    end
  end
  always_ff @(posedge i_Clock) begin
    if (push) mem[wr] <= i_Tx_Byte;
  end
endmodule

// File: tb/tb_uart_tx_buffered.sv
// tb_uart_tx_buffered: randomized checks of uart_tx_buffered against a frame-level queue model.
module tb_uart_tx_buffered;
  localparam int C = 4;
  localparam int D = 4;
  localparam int CW = $clog2(D + 1);
  localparam int FL = 10 * C;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic dv = 1'b0;
  logic [7:0] din = '0;
  logic ready, serial, active, done;
  logic [CW-1:0] count;
  int checks = 0;
  int failures = 0;
  logic [7:0] q[$];
  bit busy = 0;
  int t = 0;
  logic [7:0] cur = '0;
  bit done_m = 0;
  always #5 clk = ~clk;
  uart_tx_buffered #(.CLKS_PER_BIT(C), .FIFO_DEPTH(D)) dut (
    .i_Clock(clk), .i_Rst_n(rst_n), .i_Tx_DV(dv), .i_Tx_Byte(din),
    .o_Tx_Ready(ready), .o_Tx_Serial(serial), .o_Tx_Active(active),
    .o_Tx_Done(done), .o_Fifo_Count(count)
  );
  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h t=%0t", tag, got, exp, $time);
    end
  endtask
  function automatic bit pop_due();
    return q.size() > 0 && (!busy || t == FL - 1);
  endfunction
  function automatic logic line_exp();
    int k;
    k = t / C;
    if (!busy || k == 9) return 1'b1;
    if (k == 0) return 1'b0;
    return cur[k-1];
  endfunction
  task automatic compare_all();
    check("serial", 32'(serial), 32'(line_exp()));
    check("active", 32'(active), 32'(busy));
    check("done", 32'(done), 32'(done_m));
    check("count", 32'(count), 32'(q.size()));
    check("ready", 32'(ready), 32'(q.size() < D || pop_due()));
  endtask
  task automatic model_reset();
    q.delete();
    busy = 0;
    t = 0;
    done_m = 0;
  endtask
  task automatic step(input bit v, input logic [7:0] b);
    bit e, p, ps;
    dv = v;
    din = b;
    @(posedge clk);
    e = busy && t == FL - 1;
    p = pop_due();
    ps = v && (q.size() < D || p);
    done_m = e;
    if (p) begin
      cur = q.pop_front();
      busy = 1;
      t = 0;
    end else if (e) busy = 0;
    else if (busy) t++;
    if (ps) q.push_back(b);
    @(negedge clk);
    compare_all();
  endtask
  task automatic drain(input int limit);
    int n;
    n = 0;
    while ((busy || q.size() > 0) && n < limit) begin
      step(0, 8'h00);
      n++;
    end
    check("drain_bound", 32'(busy || q.size() > 0), 32'd0);
  endtask
  initial begin
    @(negedge clk);
    @(negedge clk);
    model_reset();
    compare_all();
    rst_n = 1'b1;
    step(1, 8'hA5);
    drain(100);
    step(1, 8'h00);
    step(1, 8'hFF);
    step(1, 8'h55);
    drain(200);
    for (int i = 0; i < 6; i++) step(1, 8'(8'h10 + i));
    for (int i = 0; i < 100; i++) step(1, 8'($urandom));
    drain(300);
    for (int i = 0; i < 3; i++) step(1, 8'(8'hC0 + i));
    for (int i = 0; i < 40 && t / C != 4; i++) step(0, 8'h00);
    check("reached_bit3", 32'(t / C), 32'd4);
    #2 rst_n = 1'b0;
    #1;
    model_reset();
    check("rst_serial", 32'(serial), 32'd1);
    check("rst_count", 32'(count), 32'd0);
    check("rst_active", 32'(active), 32'd0);
    check("rst_done", 32'(done), 32'd0);
    check("rst_ready", 32'(ready), 32'd1);
    @(negedge clk);
    compare_all();
    rst_n = 1'b1;
    step(1, 8'h3C);
    drain(100);
    for (int ph = 0; ph < 3; ph++)
      for (int i = 0; i < 700; i++)
        step($urandom_range(0, 4 * ph + 1) == 0, 8'($urandom));
    drain(300);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
